// File: rtl/asg_pkg.sv
// Shared types and constants for the arithmetic-sequence checker.
//   ASG_W            : term / a1 / d / n width
//   ASG_ACC_W        : accumulator and closed-form arithmetic width
//   asg_chk_state_t  : checker FSM state encoding
//   asg_sext         : sign-extend a term-width value to accumulator width
package asg_pkg;

  localparam int unsigned ASG_W     = 32;
  localparam int unsigned ASG_ACC_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPUTE = 2'd2,
    REPORT  = 2'd3
  } asg_chk_state_t;

  function automatic logic [ASG_ACC_W-1:0] asg_sext(input logic [ASG_W-1:0] x);
    return {{(ASG_ACC_W - ASG_W){x[ASG_W-1]}}, x};
  endfunction

endpackage : asg_pkg

// File: rtl/asg_serial_mul.sv
// Unsigned shift-add multiplier, low ACC_W bits of the product only.
// One load cycle (start accepted while idle) then ACC_W iterations; done
// pulses for one cycle with p valid and p holds until the next load.
// A new start is accepted in the done cycle, so products run back-to-back.
//   clk, rst : clock, asynchronous active-high reset
//   start    : load a/b when not busy
//   abort    : drop any product in progress (wins over start)
//   a, b     : operands
//   busy     : product in progress
//   done     : one-cycle completion pulse
//   p        : product (mod 2^ACC_W)
module asg_serial_mul
  import asg_pkg::*;
#(
  parameter int unsigned ACC_W = ASG_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] p
);

  localparam int unsigned CNT_W = $clog2(ACC_W);

  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [ACC_W-1:0] acc_q,    acc_d;
  logic [ACC_W-1:0] mcand_q,  mcand_d;
  logic [ACC_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  // Load / iterate / abort control.
  always_comb begin
    busy_d   = busy_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start && !busy_q) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(ACC_W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign p    = acc_q;

endmodule : asg_serial_mul

// File: rtl/asg_seq_checker.sv
// Checks an arithmetic-sequence term stream against a1/d/n, accumulates the
// running sum and count, computes the closed-form sum n*a1 + d*(n*(n-1)/2)
// on a shared serial multiplier, and reports a pass/fail verdict.
//   clk, rst     : clock, asynchronous active-high reset
//   enable       : run enable (shared with the generator)
//   a1, d, n     : first term (signed), difference (signed), count (unsigned)
//   term_in      : generator term (signed), qualified by term_valid
//   seq_done     : generator done level
//   sum, count   : running sum (signed) and accepted-term count
//   busy         : in COLLECT or COMPUTE
//   result_valid : verdict valid, held in REPORT
//   pass         : no error flag set
//   step_err, count_err, sum_err : individual error flags
module asg_seq_checker
  import asg_pkg::*;
#(
  parameter int unsigned W     = ASG_W,
  parameter int unsigned ACC_W = ASG_ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [W-1:0]     a1,
  input  logic [W-1:0]     d,
  input  logic [W-1:0]     n,
  input  logic [W-1:0]     term_in,
  input  logic             term_valid,
  input  logic             seq_done,
  output logic [ACC_W-1:0] sum,
  output logic [W-1:0]     count,
  output logic             busy,
  output logic             result_valid,
  output logic             pass,
  output logic             step_err,
  output logic             count_err,
  output logic             sum_err
);

  asg_chk_state_t   state_q, state_d;
  logic [W-1:0]     a1_q, a1_d;
  logic [W-1:0]     d_q, d_d;
  logic [W-1:0]     n_q, n_d;
  logic [W-1:0]     prev_q, prev_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [W-1:0]     count_q, count_d;
  logic             busy_q, busy_d;
  logic             result_valid_q, result_valid_d;
  logic             pass_q, pass_d;
  logic             step_err_q, step_err_d;
  logic             count_err_q, count_err_d;
  logic             sum_err_q, sum_err_d;
  logic [1:0]       phase_q, phase_d;
  logic [ACC_W-1:0] m1_q, m1_d;
  logic [ACC_W-1:0] m2_q, m2_d;

  logic             accept_c;
  logic             bad_step_c;
  logic [1:0]       op_idx_c;
  logic [ACC_W-1:0] expected_c;
  logic [ACC_W-1:0] n_ext_c;

  logic             mul_start_c;
  logic [ACC_W-1:0] mul_a_c, mul_b_c;
  logic             mul_busy, mul_done;
  logic [ACC_W-1:0] mul_p;

  assign n_ext_c = ACC_W'(n_q);

  asg_serial_mul #(
    .ACC_W(ACC_W)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .start(mul_start_c),
    .abort(!enable),
    .a    (mul_a_c),
    .b    (mul_b_c),
    .busy (mul_busy),
    .done (mul_done),
    .p    (mul_p)
  );

  // Next-state, accumulation, multiplier sequencing and verdict.
  always_comb begin
    state_d        = state_q;
    a1_d           = a1_q;
    d_d            = d_q;
    n_d            = n_q;
    prev_d         = prev_q;
    sum_d          = sum_q;
    count_d        = count_q;
    result_valid_d = result_valid_q;
    pass_d         = pass_q;
    step_err_d     = step_err_q;
    count_err_d    = count_err_q;
    sum_err_d      = sum_err_q;
    phase_d        = phase_q;
    m1_d           = m1_q;
    m2_d           = m2_q;
    accept_c       = 1'b0;
    bad_step_c     = 1'b0;
    op_idx_c       = phase_q;
    expected_c     = '0;
    mul_start_c    = 1'b0;
    mul_a_c        = '0;
    mul_b_c        = '0;

    unique case (state_q)
      IDLE: begin
        sum_d          = '0;
        count_d        = '0;
        result_valid_d = 1'b0;
        pass_d         = 1'b0;
        step_err_d     = 1'b0;
        count_err_d    = 1'b0;
        sum_err_d      = 1'b0;
        if (enable) begin
          a1_d     = a1;
          d_d      = d;
          n_d      = n;
          state_d  = COLLECT;
          accept_c = term_valid;
        end
      end

      COLLECT: begin
        accept_c = term_valid;
        if (seq_done) begin
          state_d = COMPUTE;
          phase_d = 2'd0;
        end
      end

      COMPUTE: begin
        // Operands for the product being launched: in a done cycle the next
        // product starts on the same edge the finished one is captured.
        op_idx_c = mul_done ? (phase_q + 2'd1) : phase_q;
        if (mul_done) begin
          phase_d = phase_q + 2'd1;
          unique case (phase_q)
            2'd0: m1_d = mul_p;
            2'd1: m2_d = mul_p;
            default: begin
              expected_c     = m2_q + mul_p;
              count_err_d    = (count_q != n_q);
              sum_err_d      = (sum_q != expected_c);
              pass_d         = !(step_err_q | count_err_d | sum_err_d);
              result_valid_d = 1'b1;
              phase_d        = 2'd0;
              state_d        = REPORT;
            end
          endcase
        end
        if (!mul_busy && !(mul_done && phase_q == 2'd2)) begin
          mul_start_c = 1'b1;
          unique case (op_idx_c)
            2'd0: begin
              mul_a_c = n_ext_c;
              mul_b_c = n_ext_c - ACC_W'(1);
            end
            2'd1: begin
              mul_a_c = n_ext_c;
              mul_b_c = ACC_W'(asg_sext(ASG_W'(a1_q)));
            end
            default: begin
              mul_a_c = ACC_W'(asg_sext(ASG_W'(d_q)));
              mul_b_c = m1_q >> 1;
            end
          endcase
        end
      end

      REPORT: begin
      end

      default: state_d = IDLE;
    endcase

    // Term acceptance; a1_d/d_d already hold the live config in the IDLE
    // capture cycle, and count_d is zero exactly for the first term.
    if (accept_c) begin
      if (count_d == '0) begin
        bad_step_c = (term_in != a1_d);
      end else begin
        bad_step_c = ((term_in - prev_q) != d_d);
      end
      step_err_d = step_err_d | bad_step_c;
      sum_d      = sum_d + ACC_W'(asg_sext(ASG_W'(term_in)));
      if (count_d != '1) begin
        count_d = count_d + W'(1);
      end
      prev_d = term_in;
    end

    // Enable low aborts from any state.
    if (!enable) begin
      state_d        = IDLE;
      sum_d          = '0;
      count_d        = '0;
      prev_d         = '0;
      result_valid_d = 1'b0;
      pass_d         = 1'b0;
      step_err_d     = 1'b0;
      count_err_d    = 1'b0;
      sum_err_d      = 1'b0;
      phase_d        = 2'd0;
    end

    busy_d = (state_d == COLLECT) || (state_d == COMPUTE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      a1_q           <= '0;
      d_q            <= '0;
      n_q            <= '0;
      prev_q         <= '0;
      sum_q          <= '0;
      count_q        <= '0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      pass_q         <= 1'b0;
      step_err_q     <= 1'b0;
      count_err_q    <= 1'b0;
      sum_err_q      <= 1'b0;
      phase_q        <= 2'd0;
      m1_q           <= '0;
      m2_q           <= '0;
    end else begin
      state_q        <= state_d;
      a1_q           <= a1_d;
      d_q            <= d_d;
      n_q            <= n_d;
      prev_q         <= prev_d;
      sum_q          <= sum_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      pass_q         <= pass_d;
      step_err_q     <= step_err_d;
      count_err_q    <= count_err_d;
      sum_err_q      <= sum_err_d;
      phase_q        <= phase_d;
      m1_q           <= m1_d;
      m2_q           <= m2_d;
    end
  end

  assign sum          = sum_q;
  assign count        = count_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign pass         = pass_q;
  assign step_err     = step_err_q;
  assign count_err    = count_err_q;
  assign sum_err      = sum_err_q;

endmodule : asg_seq_checker
